// File: rtl/column_fetcher.sv
// Column fetcher: watches the angle index, and on every change reads one LED
// column from the frame RAM and streams it to the LED driver over valid/ready.
// A small two-entry output FIFO with read credits absorbs downstream stalls.
module column_fetcher #(
    parameter int NB_ANGLES  = 128,
    parameter int NB_LEDS    = 32,
    parameter int DATA_WIDTH = 24,
    localparam int AW         = $clog2(NB_ANGLES),
    localparam int LW         = $clog2(NB_LEDS),
    localparam int ADDR_WIDTH = AW + LW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AW-1:0]         angle,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_last,
    output logic [AW-1:0]         pix_angle,
    output logic                  busy,
    output logic                  overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Change detection and the single-slot pending request
    logic [AW-1:0] prev_angle;
    logic          change;
    logic          pending;
    logic [AW-1:0] pending_angle;
    logic          consume;
    logic          direct;
    logic          start;
    logic [AW-1:0] start_angle;

    // Column read side
    logic [AW-1:0] angle_latched;
    logic [LW-1:0] led_idx;
    logic          last_read;
    logic          credit_ok;
    logic [2:0]    occ_next;

    // Read in flight: tags travel alongside the RAM's one-cycle latency
    logic          in_flight;
    logic          in_flight_last;
    logic [AW-1:0] in_flight_angle;

    // Two-entry output FIFO
    logic [DATA_WIDTH-1:0] fifo_data  [2];
    logic                  fifo_last  [2];
    logic [AW-1:0]         fifo_angle [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            fifo_count;
    logic                  push;
    logic                  pop;

    assign change  = (angle != prev_angle);
    assign consume = (state == IDLE) && pending;
    // With nothing pending, a change seen while idle starts a column straight away
    assign direct  = (state == IDLE) && !pending && change;
    assign start   = consume || direct;
    assign start_angle = pending ? pending_angle : angle;

    assign pix_valid = (fifo_count != 2'd0);
    assign pop       = pix_valid && pix_ready;
    assign push      = in_flight;

    // Occupancy after this cycle's pop, counting reads whose data is still on its way
    assign occ_next  = 3'(fifo_count) + 3'(in_flight) - 3'(pop);
    assign credit_ok = (occ_next < 3'd2);

    assign rd_en     = (state == FETCH) && credit_ok;
    assign rd_addr   = {angle_latched, led_idx};
    assign last_read = rd_en && (led_idx == LW'(NB_LEDS - 1));
    assign busy      = (state != IDLE);

    assign pix_data  = pix_valid ? fifo_data[rd_ptr]  : '0;
    assign pix_last  = pix_valid ? fifo_last[rd_ptr]  : 1'b0;
    assign pix_angle = pix_valid ? fifo_angle[rd_ptr] : '0;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: idle until a request, read the column, then drain the FIFO
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (last_read) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && pix_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Angle tracking, pending request, overrun pulse and column read counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_angle      <= '0;
            pending         <= 1'b1;
            pending_angle   <= '0;
            overrun         <= 1'b0;
            angle_latched   <= '0;
            led_idx         <= '0;
            in_flight       <= 1'b0;
            in_flight_last  <= 1'b0;
            in_flight_angle <= '0;
        end else begin
            prev_angle <= angle;
            overrun    <= change && pending && !consume;

            if (change && !direct) begin
                pending       <= 1'b1;
                pending_angle <= angle;
            end else if (consume) begin
                pending <= 1'b0;
            end

            if (start) begin
                angle_latched <= start_angle;
                led_idx       <= '0;
            end else if (rd_en) begin
                led_idx <= led_idx + 1'b1;
            end

            in_flight       <= rd_en;
            in_flight_last  <= last_read;
            in_flight_angle <= angle_latched;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + 2'(push) - 2'(pop);
        end
    end

    // FIFO storage: RAM word plus its last/angle tags, captured when the read returns
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i]  <= '0;
                fifo_last[i]  <= 1'b0;
                fifo_angle[i] <= '0;
            end
        end else if (push) begin
            fifo_data[wr_ptr]  <= rd_data;
            fifo_last[wr_ptr]  <= in_flight_last;
            fifo_angle[wr_ptr] <= in_flight_angle;
        end
    end

endmodule

// File: tb/tb_column_fetcher.sv
// Testbench for column_fetcher: a RAM model feeds reads, a scoreboard queue
// holds the expected word stream per column and a monitor compares every
// accepted word. Downstream ready is optionally randomized.
module tb_column_fetcher;

    localparam int NB_ANGLES  = 128;
    localparam int NB_LEDS    = 32;
    localparam int DATA_WIDTH = 24;
    localparam int AW         = $clog2(NB_ANGLES);
    localparam int LW         = $clog2(NB_LEDS);
    localparam int ADDR_WIDTH = AW + LW;

    typedef struct {
        logic [AW-1:0]         ang;
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } word_t;

    logic                  clk;
    logic                  rst;
    logic [AW-1:0]         angle;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] pix_data;
    logic                  pix_valid;
    logic                  pix_ready;
    logic                  pix_last;
    logic [AW-1:0]         pix_angle;
    logic                  busy;
    logic                  overrun;

    word_t sb[$];
    int    checks;
    int    failures;
    int    pop_count;
    int    overrun_count;
    bit    rand_ready;

    logic                  held;
    logic [DATA_WIDTH-1:0] held_data;
    logic                  held_last;
    logic [AW-1:0]         held_angle;

    column_fetcher #(
        .NB_ANGLES (NB_ANGLES),
        .NB_LEDS   (NB_LEDS),
        .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .angle    (angle),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .pix_data (pix_data),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_last (pix_last),
        .pix_angle(pix_angle),
        .busy     (busy),
        .overrun  (overrun)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Contents of the frame RAM: a distinct word for every address
    function automatic logic [DATA_WIDTH-1:0] ram_word(input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] w;
        w = {a, a ^ 12'hA5C} ^ 24'h3C96E1;
        return w;
    endfunction

    // Frame RAM model: data appears one cycle after the read strobe
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data <= ram_word(rd_addr);
        end
    end

    // Downstream ready: always accepting, or a 50% coin flip per cycle
    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pix_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Monitor: compare accepted words to the scoreboard and check stall stability
    always @(negedge clk) begin
        word_t exp_w;
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                checks++;
                if (!pix_valid || pix_data !== held_data || pix_last !== held_last
                    || pix_angle !== held_angle) begin
                    failures++;
                    $display("[TB] FAIL stall_stable: got valid=%0b data=%h last=%0b angle=%0d, want valid=1 data=%h last=%0b angle=%0d",
                             pix_valid, pix_data, pix_last, pix_angle, held_data, held_last, held_angle);
                end
            end
            held       = pix_valid && !pix_ready;
            held_data  = pix_data;
            held_last  = pix_last;
            held_angle = pix_angle;

            if (pix_valid && pix_ready) begin
                checks++;
                pop_count++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_word: got data=%h angle=%0d last=%0b, want no word",
                             pix_data, pix_angle, pix_last);
                end else begin
                    exp_w = sb.pop_front();
                    if (pix_data !== exp_w.data || pix_last !== exp_w.last
                        || pix_angle !== exp_w.ang) begin
                        failures++;
                        $display("[TB] FAIL word: got data=%h angle=%0d last=%0b, want data=%h angle=%0d last=%0b",
                                 pix_data, pix_angle, pix_last, exp_w.data, exp_w.ang, exp_w.last);
                    end
                end
            end
            if (overrun) begin
                overrun_count++;
            end
        end
    end

    // Single comparison with a FAIL line on mismatch
    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    // Drive a new angle just after a clock edge
    task automatic apply_stimulus(input logic [AW-1:0] a);
        @(posedge clk);
        #1;
        angle = a;
    endtask

    // Expected stream for one full column
    task automatic push_column(input logic [AW-1:0] a);
        word_t w;
        for (int i = 0; i < NB_LEDS; i++) begin
            w.ang  = a;
            w.last = (i == NB_LEDS - 1);
            w.data = ram_word({a, LW'(i)});
            sb.push_back(w);
        end
    endtask

    // Wait until every expected word is out and the block is idle again
    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((sb.size() != 0 || busy) && n < 2000);
        check_output(name, 64'(n >= 2000), 64'd0);
        check_output({name, "_left"}, 64'(sb.size()), 64'd0);
    endtask

    // Every output at zero, as required during and right after reset
    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_pix_valid"}, 64'(pix_valid), 64'd0);
        check_output({tag, "_rd_en"}, 64'(rd_en), 64'd0);
        check_output({tag, "_busy"}, 64'(busy), 64'd0);
        check_output({tag, "_overrun"}, 64'(overrun), 64'd0);
        check_output({tag, "_pix_data"}, 64'(pix_data), 64'd0);
        check_output({tag, "_pix_last"}, 64'(pix_last), 64'd0);
        check_output({tag, "_pix_angle"}, 64'(pix_angle), 64'd0);
        check_output({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
    endtask

    // Directed scenarios with randomized angles and ready patterns
    initial begin
        logic [AW-1:0] ra;
        int            base;
        int            n;
        checks        = 0;
        failures      = 0;
        pop_count     = 0;
        overrun_count = 0;
        rand_ready    = 1'b0;
        held          = 1'b0;
        rst           = 1'b1;
        angle         = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        // Column 0 comes out by itself after reset release
        push_column('0);
        rst = 1'b0;
        wait_idle("col0_after_reset");

        // Column 5, then 5->6 with the first-word latency checked
        apply_stimulus(7'd5);
        push_column(7'd5);
        wait_idle("col5");
        apply_stimulus(7'd6);
        push_column(7'd6);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_output("latency_2_edges_valid", 64'(pix_valid), 64'd0);
        @(posedge clk);
        #1;
        check_output("latency_3_edges_valid", 64'(pix_valid), 64'd1);
        wait_idle("col6");
        check_output("overrun_none_yet", 64'(overrun_count), 64'd0);

        // Random stalls over a random column
        for (int k = 0; k < 2; k++) begin
            ra = AW'($urandom_range(13, 100));
            rand_ready = 1'b1;
            apply_stimulus(ra);
            push_column(ra);
            wait_idle("col_random_ready");
            rand_ready = 1'b0;
        end
        check_output("overrun_after_random", 64'(overrun_count), 64'd0);

        // 10 -> 11 -> 12 within one column: 11 skipped, one overrun
        apply_stimulus(7'd10);
        push_column(7'd10);
        repeat (5) @(posedge clk);
        apply_stimulus(7'd11);
        repeat (5) @(posedge clk);
        apply_stimulus(7'd12);
        push_column(7'd12);
        wait_idle("col10_then_12");
        check_output("overrun_once", 64'(overrun_count), 64'd1);

        // Wrap from the last angle back to 0
        apply_stimulus(7'd127);
        push_column(7'd127);
        wait_idle("col127");
        apply_stimulus(7'd0);
        push_column(7'd0);
        wait_idle("col0_wrap");
        check_output("overrun_after_wrap", 64'(overrun_count), 64'd1);

        // Reset in the middle of column 3
        apply_stimulus(7'd3);
        push_column(7'd3);
        base = pop_count;
        n = 0;
        while (pop_count < base + 10 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output("mid_col_reached", 64'(n >= 500), 64'd0);
        check_output("busy_before_rst", 64'(busy), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        sb.delete();
        angle = '0;
        repeat (2) @(posedge clk);
        #1;
        push_column('0);
        rst = 1'b0;
        wait_idle("col0_after_mid_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
